priority_enc_sched: RTL



---
 rtl/penc_pkg.sv | 16 +
 rtl/penc_pick.sv | 28 ++
 rtl/priority_enc_sched.sv | 110 +++++++++++
 3 files changed

// File: rtl/penc_pkg.sv
// Shared constants and helpers for the priority-encoder scheduler.
package penc_pkg;

    localparam int PENC_MAX_N = 64;

    // Index width for n entries, never less than one bit.
    function automatic int clog2_min1(input int n);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) w = i + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/penc_pick.sv
// Highest-set-bit picker: reports whether any bit is set and its index.
// Latency: combinational.
// Backpressure: none; pure function of vec.
module penc_pick
    import penc_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0]                vec,
    output logic                        found,
    output logic [clog2_min1(N)-1:0]    idx
);

    localparam int W = clog2_min1(N);

    // Ascending scan so the last (highest) set bit wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            if (vec[i]) begin
                found = 1'b1;
                idx   = W'(i);
            end
        end
    end

endmodule

// File: rtl/priority_enc_sched.sv
// Sticky request capture issuing one index at a time; PENC_ROUND_ROBIN_EN selects round-robin over fixed priority.
// Latency: req at edge k reaches pending at k, out_valid at k+1; one issue per cycle.
// Backpressure: out_idx/out_valid hold while out_valid & !out_ready; intake keeps accumulating.
module priority_enc_sched
    import penc_pkg::*;
#(
    parameter int N = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        en,
    input  logic [N-1:0]                req,
    input  logic                        out_ready,
    output logic                        out_valid,
    output logic [clog2_min1(N)-1:0]    out_idx,
    output logic [N-1:0]                pending,
    output logic                        ovf
);

    localparam int W = clog2_min1(N);

    if (N < 2 || N > PENC_MAX_N) begin : g_bad_n
        $error("priority_enc_sched: N out of range");
    end

    logic           free;
    logic           found;
    logic           load;
    logic [W-1:0]   win;
    logic [N-1:0]   load_oh;
    logic [N-1:0]   pending_nxt;
    logic           ovf_nxt;

    assign free = !out_valid || out_ready;
    assign load = free && found;

`ifdef PENC_ROUND_ROBIN_EN
    logic [W-1:0]   ptr;
    logic [N-1:0]   below;
    logic           m_found;
    logic           u_found;
    logic [W-1:0]   m_idx;
    logic [W-1:0]   u_idx;

    always_comb begin
        below = '0;
        for (int i = 0; i < N; i++) begin
            below[i] = (W'(i) < ptr);
        end
    end

    penc_pick #(.N(N)) u_pick_masked (
        .vec   (pending & below),
        .found (m_found),
        .idx   (m_idx)
    );

    penc_pick #(.N(N)) u_pick_all (
        .vec   (pending),
        .found (u_found),
        .idx   (u_idx)
    );

    // Prefer the next index below the last winner, otherwise wrap to the top.
    assign found = u_found;
    assign win   = m_found ? m_idx : u_idx;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr <= W'(N - 1);
        end else if (load) begin
            ptr <= win;
        end
    end
`else
    penc_pick #(.N(N)) u_pick (
        .vec   (pending),
        .found (found),
        .idx   (win)
    );
`endif

    always_comb begin
        load_oh = '0;
        for (int i = 0; i < N; i++) begin
            load_oh[i] = load && (win == W'(i));
        end
    end

    // Set wins over clear, so a req on the bit being loaded re-arms it.
    assign pending_nxt = (pending & ~load_oh) | (en ? req : '0);
    assign ovf_nxt     = en && |(req & pending & ~load_oh);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending   <= '0;
            out_valid <= 1'b0;
            out_idx   <= '0;
            ovf       <= 1'b0;
        end else begin
            pending <= pending_nxt;
            ovf     <= ovf_nxt;
            if (free) begin
                out_valid <= found;
                if (found) out_idx <= win;
            end
        end
    end

endmodule
